// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported word memory between the instruction-fetch port
//   and the load/store data port. Each granted request runs one memory
//   valid/ready handshake and produces exactly one requester ready pulse.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_valid/i_addr           fetch request (held until i_ready)
//   i_ready/i_rdata          fetch completion pulse and read data
//   d_valid/d_wen/d_addr/    data request (d_wen = 0000 is a load)
//   d_wdata
//   d_ready/d_rdata          data completion pulse and load data
//   mem_valid/mem_wen/       memory request, byte enables, address, write data
//   mem_addr/mem_wdata
//   mem_ready/mem_rdata      memory completion and read data
//   grant_d                  1 = current/last transaction owned by data port
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   : priority alternates after each completion
//                       undefined : fixed priority, data over fetch
//
// States:
//   IDLE | waiting for a request, arbitrates and issues to memory
//   BUSY | memory request outstanding, waiting for mem_ready
//   DONE | one dead cycle absorbing held valid and trailing mem_ready

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic [31:0]           i_rdata,
  input  logic                  d_valid,
  input  logic [3:0]            d_wen,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_ready,
  output logic [31:0]           d_rdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [3:0]            mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  grant_d
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [3:0]            mem_wen_q, mem_wen_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  i_ready_q, i_ready_d;
  logic                  d_ready_q, d_ready_d;
  logic [31:0]           i_rdata_q, i_rdata_d;
  logic [31:0]           d_rdata_q, d_rdata_d;
  logic                  grant_data_q, grant_data_d;
  logic                  pick_data;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data port currently holds priority
  logic prio_data_q, prio_data_d;

  always_comb begin
    pick_data = d_valid && (prio_data_q || !i_valid);
  end
`else
  always_comb begin
    pick_data = d_valid;
  end
`endif

  always_comb begin
    state_d      = state_q;
    mem_valid_d  = mem_valid_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_data_d = grant_data_q;
`ifdef ARB_ROUND_ROBIN_EN
    prio_data_d  = prio_data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_valid || d_valid) begin
          mem_valid_d  = 1'b1;
          grant_data_d = pick_data;
          if (pick_data) begin
            mem_addr_d  = d_addr;
            mem_wen_d   = d_wen;
            mem_wdata_d = d_wdata;
          end else begin
            mem_addr_d  = i_addr;
            mem_wen_d   = 4'b0000;
            mem_wdata_d = 32'h0;
          end
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (grant_data_q) begin
            d_rdata_d = mem_rdata;
            d_ready_d = 1'b1;
          end else begin
            i_rdata_d = mem_rdata;
            i_ready_d = 1'b1;
          end
`ifdef ARB_ROUND_ROBIN_EN
          // port just served drops to lowest priority
          prio_data_d = !grant_data_q;
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_valid_q  <= 1'b0;
      mem_wen_q    <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_rdata_q    <= 32'h0;
      d_rdata_q    <= 32'h0;
      grant_data_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      prio_data_q  <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      mem_valid_q  <= mem_valid_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      grant_data_q <= grant_data_d;
`ifdef ARB_ROUND_ROBIN_EN
      prio_data_q  <= prio_data_d;
`endif
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign grant_d   = grant_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_valid = 1'b0;
  logic [3:0]  d_wen = 4'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        grant_d;

  int errors = 0;
  int checks = 0;
  int i_cnt = 0;
  int d_cnt = 0;

  logic [31:0] dev_mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] fq [$];
  logic [31:0] dq [$];
  int          comp_log [$];
  logic [31:0] w;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .grant_d(grant_d)
  );

  // Registered write-first memory: ready one cycle after valid is sampled.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      mem_ready <= mem_valid;
      if (mem_valid) begin
        w = dev_mem[mem_addr[9:2]];
        for (int b = 0; b < 4; b++)
          if (mem_wen[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        dev_mem[mem_addr[9:2]] <= w;
        mem_rdata <= w;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected responses whenever a ready pulse is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (i_ready && d_ready) chk("both_ready", 32'd1, 32'd0);
        if (i_ready) begin
          i_cnt++;
          comp_log.push_back(0);
          chk("grant_d_on_i", {31'b0, grant_d}, 32'd0);
          if (fq.size() == 0) chk("unexpected_i_ready", 32'd1, 32'd0);
          else chk("i_rdata", i_rdata, fq.pop_front());
        end
        if (d_ready) begin
          d_cnt++;
          comp_log.push_back(1);
          chk("grant_d_on_d", {31'b0, grant_d}, 32'd1);
          if (dq.size() == 0) chk("unexpected_d_ready", 32'd1, 32'd0);
          else chk("d_rdata", d_rdata, dq.pop_front());
        end
      end
    end
  end

  // Called #1 after a rising edge; returns negedges waited until ready.
  task automatic do_fetch(input logic [31:0] a, output int n);
    fq.push_back(ref_mem[a[9:2]]);
    i_addr = a;
    i_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_ready && n < 30);
    if (!i_ready) begin
      errors++; checks++;
      $display("FAIL fetch_timeout: got no i_ready expected i_ready addr %h", a);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic do_data(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd);
    int n;
    logic [31:0] m;
    m = ref_mem[a[9:2]];
    for (int b = 0; b < 4; b++)
      if (wen[b]) m[8*b +: 8] = wd[8*b +: 8];
    ref_mem[a[9:2]] = m;
    dq.push_back(m);
    d_addr = a; d_wen = wen; d_wdata = wd;
    d_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ready && n < 30);
    if (!d_ready) begin
      errors++; checks++;
      $display("FAIL data_timeout: got no d_ready expected d_ready addr %h", a);
    end
    @(posedge clk); #1;
    d_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ic0, dc0;
    int exp_order [$];
    bit prio_data;
    for (int k = 0; k < 256; k++) begin
      dev_mem[k] = $urandom;
      ref_mem[k] = dev_mem[k];
    end
    dev_mem[4] = 32'h00018EB7;  ref_mem[4] = 32'h00018EB7;
    dev_mem[9] = 32'h11223344;  ref_mem[9] = 32'h11223344;

    repeat (3) @(negedge clk);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_mem_wen", {28'b0, mem_wen}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_ready", {30'b0, i_ready, d_ready}, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    chk("rst_grant_d", {31'b0, grant_d}, 32'd0);
    rst = 1'b0;

    // Fetch only, cycle-exact latency
    @(posedge clk); #1;
    fq.push_back(ref_mem[4]);
    i_addr = 32'h10; i_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lat_mem_valid", {31'b0, mem_valid}, 32'd1);
    chk("lat_mem_addr", mem_addr, 32'h10);
    chk("lat_mem_wen", {28'b0, mem_wen}, 32'd0);
    chk("lat_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    chk("lat_not_ready_yet", {31'b0, i_ready}, 32'd0);
    @(negedge clk);
    chk("lat_i_ready", {31'b0, i_ready}, 32'd1);
    chk("lat_i_rdata", i_rdata, 32'h00018EB7);
    chk("lat_mem_valid_fall", {31'b0, mem_valid}, 32'd0);
    // valid still high in the DONE edge; must not cause a second grant
    @(posedge clk); #1; i_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_valid_one_ready", i_cnt, 32'd1);
    chk("i_rdata_hold", i_rdata, 32'h00018EB7);
    @(posedge clk); #1;

    // Store then load, byte store
    ic0 = i_cnt;
    do_data(32'h20, 4'b1111, 32'hDEADBEEF);
    do_data(32'h20, 4'b0000, 32'h0);
    chk("load_deadbeef", d_rdata, 32'hDEADBEEF);
    do_data(32'h24, 4'b0010, 32'h0000AB00);
    do_data(32'h24, 4'b0000, 32'h0);
    chk("byte_store_merge", d_rdata, 32'h1122AB44);
    chk("no_i_ready_on_data", i_cnt, ic0);

    // Reset while BUSY
    i_addr = 32'h14; i_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", {31'b0, mem_valid}, 32'd1);
    rst = 1'b1; #1;
    chk("async_rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("async_rst_ready", {30'b0, i_ready, d_ready}, 32'd0);
    i_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_fetch(32'h18, n);
    chk("post_rst_latency", n, 32'd4);

    // Contention from a known priority state
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    comp_log.delete();
    exp_order.delete();
    prio_data = 1'b1;
    for (int r = 0; r < 2; r++) begin
      int first;
      first = prio_data ? 1 : 0;
      exp_order.push_back(first);
      exp_order.push_back(1 - first);
`ifdef ARB_ROUND_ROBIN_EN
      prio_data = (first == 1);  // second served was fetch -> data next
`endif
      fork
        do_fetch(32'h40 + 4*r, n);
        do_data(32'h240 + 4*r, 4'b0000, 32'h0);
      join
    end
    chk("contention_count", comp_log.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < comp_log.size()) chk("contention_order", comp_log[k], exp_order[k]);

    // Randomized concurrent traffic (fetch and data use disjoint regions)
    ic0 = i_cnt; dc0 = d_cnt;
    fork
      begin
        int nn;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          if (!$isunknown(i_valid)) #0;
          do_fetch({22'b0, 1'b0, 7'($urandom_range(0, 127)), 2'b00}, nn);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          logic [3:0] we;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
          do_data({22'b0, 1'b1, 7'($urandom_range(0, 127)), 2'b00}, we, $urandom);
        end
      end
    join
    repeat (6) @(negedge clk);
    chk("rand_i_count", i_cnt - ic0, 32'd40);
    chk("rand_d_count", d_cnt - dc0, 32'd40);
    chk("fq_drained", fq.size(), 32'd0);
    chk("dq_drained", dq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
